// File: rtl/tank_plant_emulator_if.sv
// Actuator/sensor bundle between the irrigation controller (master) and the
// plant emulator (slave): valve commands and test preload in, sensors out.
interface tank_plant_emulator_if;
    logic       Ve;
    logic       A;
    logic       G;
    logic       Ld;
    logic [7:0] LdVol;
    logic [7:0] LdSoil;
    logic       Nv1;
    logic       Nv0;
    logic       Us;
    logic       Ovf;
    logic       DryRun;
    logic [7:0] Vol;
    logic [7:0] Soil;

    modport master (
        output Ve, A, G, Ld, LdVol, LdSoil,
        input  Nv1, Nv0, Us, Ovf, DryRun, Vol, Soil
    );

    modport slave (
        input  Ve, A, G, Ld, LdVol, LdSoil,
        output Nv1, Nv0, Us, Ovf, DryRun, Vol, Soil
    );
endinterface

// File: rtl/tank_plant_emulator.sv
// Tick-based emulator of the water reservoir and soil bed: integrates valve
// commands once per TICK_DIV clocks and presents registered level/dryness sensors.
module tank_plant_emulator #(
    parameter int TICK_DIV  = 50000000,
    parameter int VOL_MAX   = 200,
    parameter int VOL_INIT  = 100,
    parameter int FILL_RATE = 8,
    parameter int A_RATE    = 6,
    parameter int G_RATE    = 2,
    parameter int LVL1      = 50,
    parameter int LVL2      = 100,
    parameter int LVL3      = 150,
    parameter int SOIL_MAX  = 255,
    parameter int SOIL_INIT = 40,
    parameter int A_GAIN    = 5,
    parameter int G_GAIN    = 3,
    parameter int DRY_RATE  = 1,
    parameter int DRY_TH    = 30,
    parameter int WET_TH    = 120
) (
    input logic                  Clk,
    input logic                  Rst,
    tank_plant_emulator_if.slave io
);

    localparam int              PreW      = $clog2(TICK_DIV);
    localparam logic [PreW-1:0] PreLast   = PreW'(TICK_DIV - 1);
    localparam logic [7:0]      VolMax8   = 8'(VOL_MAX);
    localparam logic [7:0]      SoilMax8  = 8'(SOIL_MAX);
    localparam logic signed [11:0] VolMaxS   = 12'(VOL_MAX);
    localparam logic signed [11:0] SoilMaxS  = 12'(SOIL_MAX);
    localparam logic signed [11:0] FillRateS = 12'(FILL_RATE);
    localparam logic signed [11:0] ARateS    = 12'(A_RATE);
    localparam logic signed [11:0] GRateS    = 12'(G_RATE);
    localparam logic signed [11:0] AGainS    = 12'(A_GAIN);
    localparam logic signed [11:0] GGainS    = 12'(G_GAIN);
    localparam logic signed [11:0] DryRateS  = 12'(DRY_RATE);

    function automatic logic [1:0] levelCode(input logic [7:0] v);
        logic [1:0] code;
        if (v < 8'(LVL1))      code = 2'b00;
        else if (v < 8'(LVL2)) code = 2'b01;
        else if (v < 8'(LVL3)) code = 2'b10;
        else                   code = 2'b11;
        return code;
    endfunction

    // Dry flag sets at or below DRY_TH, clears at or above WET_TH, holds between.
    function automatic logic usHyst(input logic [7:0] m, input logic usPrev);
        logic us;
        if (m <= 8'(DRY_TH))      us = 1'b1;
        else if (m >= 8'(WET_TH)) us = 1'b0;
        else                      us = usPrev;
        return us;
    endfunction

    logic [PreW-1:0]    preReg, preNext;
    logic [7:0]         volReg, volNext;
    logic [7:0]         soilReg, soilNext;
    logic [1:0]         nvReg, nvNext;
    logic               usReg, usNext;
    logic               ovfReg, ovfNext;
    logic               dryRunReg, dryRunNext;
    logic signed [11:0] volSum;
    logic signed [11:0] soilSum;
    logic               tick;

    assign tick = (preReg == PreLast);

    always_comb begin
        preNext    = tick ? '0 : preReg + 1'b1;
        volNext    = volReg;
        soilNext   = soilReg;
        ovfNext    = 1'b0;
        dryRunNext = 1'b0;
        volSum     = '0;
        soilSum    = '0;

        if (io.Ld) begin
            preNext  = '0;
            volNext  = (io.LdVol > VolMax8) ? VolMax8 : io.LdVol;
            soilNext = (io.LdSoil > SoilMax8) ? SoilMax8 : io.LdSoil;
        end else if (tick) begin
            volSum = $signed({4'b0000, volReg});
            if (io.Ve) volSum = volSum + FillRateS;
            if (io.A)  volSum = volSum - ARateS;
            if (io.G)  volSum = volSum - GRateS;
            if (volSum < 12'sd0)       volNext = 8'd0;
            else if (volSum > VolMaxS) volNext = VolMax8;
            else                       volNext = volSum[7:0];

            // Valves only wet the soil while the tank still holds water.
            soilSum = $signed({4'b0000, soilReg}) - DryRateS;
            if (volReg != 8'd0) begin
                if (io.A) soilSum = soilSum + AGainS;
                if (io.G) soilSum = soilSum + GGainS;
            end
            if (soilSum < 12'sd0)        soilNext = 8'd0;
            else if (soilSum > SoilMaxS) soilNext = SoilMax8;
            else                         soilNext = soilSum[7:0];

            ovfNext    = io.Ve && (volReg == VolMax8);
            dryRunNext = (io.A || io.G) && (volReg == 8'd0);
        end

        nvNext = levelCode(volNext);
        usNext = usHyst(soilNext, usReg);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            preReg    <= '0;
            volReg    <= 8'(VOL_INIT);
            soilReg   <= 8'(SOIL_INIT);
            nvReg     <= levelCode(8'(VOL_INIT));
            usReg     <= (SOIL_INIT <= DRY_TH);
            ovfReg    <= 1'b0;
            dryRunReg <= 1'b0;
        end else begin
            preReg    <= preNext;
            volReg    <= volNext;
            soilReg   <= soilNext;
            nvReg     <= nvNext;
            usReg     <= usNext;
            ovfReg    <= ovfNext;
            dryRunReg <= dryRunNext;
        end
    end

    assign io.Vol    = volReg;
    assign io.Soil   = soilReg;
    assign io.Nv1    = nvReg[1];
    assign io.Nv0    = nvReg[0];
    assign io.Us     = usReg;
    assign io.Ovf    = ovfReg;
    assign io.DryRun = dryRunReg;

endmodule

// File: tb/tb_tank_plant_emulator.sv
// Randomised and directed stimulus for tank_plant_emulator, checked per clock
// against a tick-level plant model through an expectation queue.
module tb_tank_plant_emulator;

    localparam int TICK_DIV  = 4;
    localparam int VOL_MAX   = 200;
    localparam int VOL_INIT  = 100;
    localparam int FILL_RATE = 8;
    localparam int A_RATE    = 6;
    localparam int G_RATE    = 2;
    localparam int SOIL_MAX  = 255;
    localparam int SOIL_INIT = 40;
    localparam int A_GAIN    = 5;
    localparam int G_GAIN    = 3;
    localparam int DRY_RATE  = 1;
    localparam int DRY_TH    = 30;
    localparam int WET_TH    = 120;

    typedef struct {
        int         cyc;
        int         kind;   // 0 idle, 1 reset, 2 load, 3 tick
        logic [7:0] vol;
        logic [7:0] soil;
        logic [1:0] nv;
        logic       us;
        logic       ovf;
        logic       dry;
    } expT;

    logic clk;
    logic rst;
    int   edgeCnt = 0;
    int   testCnt = 0;
    int   failCnt = 0;
    expT  expQ[$];
    expT  e;

    // Reference plant state
    int mV = 0;
    int mM = 0;
    int mSince = 0;
    bit mUs = 1'b0;

    tank_plant_emulator_if io();

    tank_plant_emulator #(
        .TICK_DIV(TICK_DIV)
    ) dut (
        .Clk(clk),
        .Rst(rst),
        .io (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    function automatic logic [1:0] refLevel(input int v);
        if (v < 50)  return 2'b00;
        if (v < 100) return 2'b01;
        if (v < 150) return 2'b10;
        return 2'b11;
    endfunction

    function automatic bit refUs(input int m, input bit prev);
        if (m <= DRY_TH) return 1'b1;
        if (m >= WET_TH) return 1'b0;
        return prev;
    endfunction

    function automatic int clampInt(input int x, input int hi);
        if (x < 0)  return 0;
        if (x > hi) return hi;
        return x;
    endfunction

    // One clock edge: apply inputs, advance the model, queue the expected outputs.
    task automatic stepEdge(input bit r, input bit ld, input logic [7:0] lv,
                            input logic [7:0] ls, input bit ve, input bit a, input bit g);
        expT x;
        bit  ovf;
        bit  dry;
        int  kind;
        rst       = r;
        io.Ld     = ld;
        io.LdVol  = lv;
        io.LdSoil = ls;
        io.Ve     = ve;
        io.A      = a;
        io.G      = g;
        @(posedge clk);
        #1;
        ovf  = 1'b0;
        dry  = 1'b0;
        kind = 0;
        if (r) begin
            mV = VOL_INIT;
            mM = SOIL_INIT;
            mUs = (SOIL_INIT <= DRY_TH);
            mSince = 0;
            kind = 1;
        end else if (ld) begin
            mV = (int'(lv) > VOL_MAX) ? VOL_MAX : int'(lv);
            mM = (int'(ls) > SOIL_MAX) ? SOIL_MAX : int'(ls);
            mUs = refUs(mM, mUs);
            mSince = 0;
            kind = 2;
        end else begin
            mSince++;
            if (mSince == TICK_DIV) begin
                int wet;
                mSince = 0;
                kind = 3;
                ovf = ve && (mV == VOL_MAX);
                dry = (a || g) && (mV == 0);
                wet = (mV > 0) ? ((a ? A_GAIN : 0) + (g ? G_GAIN : 0)) : 0;
                mM = clampInt(mM + wet - DRY_RATE, SOIL_MAX);
                mV = clampInt(mV + (ve ? FILL_RATE : 0) - (a ? A_RATE : 0) - (g ? G_RATE : 0), VOL_MAX);
                mUs = refUs(mM, mUs);
            end
        end
        x.cyc  = edgeCnt;
        x.kind = kind;
        x.vol  = 8'(mV);
        x.soil = 8'(mM);
        x.nv   = refLevel(mV);
        x.us   = mUs;
        x.ovf  = ovf;
        x.dry  = dry;
        expQ.push_back(x);
    endtask

    // A full tick period starting at phase 0; valves glitch randomly until the tick edge.
    task automatic period(input bit ve, input bit a, input bit g);
        for (int i = 0; i < TICK_DIV - 1; i++)
            stepEdge(1'b0, 1'b0, 8'd0, 8'd0, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        stepEdge(1'b0, 1'b0, 8'd0, 8'd0, ve, a, g);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) stepEdge(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0 && expQ[0].cyc < edgeCnt) begin
            e = expQ.pop_front();
            testCnt++;
            failCnt++;
            $display("[TB] FAIL stale_expectation cyc=%0d now=%0d", e.cyc, edgeCnt);
        end else if (expQ.size() > 0 && expQ[0].cyc == edgeCnt) begin
            e = expQ.pop_front();
            testCnt++;
            if (io.Vol !== e.vol || io.Soil !== e.soil || {io.Nv1, io.Nv0} !== e.nv ||
                io.Us !== e.us || io.Ovf !== e.ovf || io.DryRun !== e.dry) begin
                failCnt++;
                $display("[TB] FAIL outputs cyc=%0d kind=%0d got vol=%0d soil=%0d nv=%b us=%b ovf=%b dry=%b required vol=%0d soil=%0d nv=%b us=%b ovf=%b dry=%b",
                         e.cyc, e.kind, io.Vol, io.Soil, {io.Nv1, io.Nv0}, io.Us, io.Ovf, io.DryRun,
                         e.vol, e.soil, e.nv, e.us, e.ovf, e.dry);
            end else if (e.kind != 0) begin
                $display("[TB] cyc=%0d %s vol=%0d soil=%0d nv=%b us=%b ovf=%b dry=%b",
                         e.cyc, (e.kind == 1) ? "rst " : (e.kind == 2) ? "load" : "tick",
                         e.vol, e.soil, e.nv, e.us, e.ovf, e.dry);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        io.Ld     = 1'b0;
        io.LdVol  = 8'd0;
        io.LdSoil = 8'd0;
        io.Ve     = 1'b0;
        io.A      = 1'b0;
        io.G      = 1'b0;

        // Reset, then first tick lands on the TICK_DIV-th edge
        stepEdge(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        stepEdge(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        period(1'b1, 1'b0, 1'b0);
        period(1'b0, 1'b0, 1'b0);

        // Fill into a full tank: clamp, then overflow pulse
        stepEdge(1'b0, 1'b1, 8'd195, 8'd60, 1'b0, 1'b0, 1'b0);
        period(1'b1, 1'b0, 1'b0);
        period(1'b1, 1'b0, 1'b0);

        // Draining to empty, then dry-run on an empty tank
        stepEdge(1'b0, 1'b1, 8'd7, 8'd100, 1'b0, 1'b0, 1'b0);
        period(1'b0, 1'b1, 1'b1);
        period(1'b0, 1'b1, 1'b1);

        // Hysteresis: dry set at 30, held on the way up until >= 120
        stepEdge(1'b0, 1'b1, 8'd100, 8'd31, 1'b0, 1'b0, 1'b0);
        period(1'b0, 1'b0, 1'b0);
        stepEdge(1'b0, 1'b1, 8'd200, 8'd30, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 24; i++) period(1'b0, 1'b1, 1'b0);

        // All valves open: net zero
        stepEdge(1'b0, 1'b1, 8'd100, 8'd100, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) period(1'b1, 1'b1, 1'b1);

        // Load then reset mid-period; load and reset together; load clamp alone
        stepEdge(1'b0, 1'b1, 8'd20, 8'd200, 1'b0, 1'b0, 1'b0);
        idle(2);
        stepEdge(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        stepEdge(1'b1, 1'b1, 8'd255, 8'd255, 1'b0, 1'b0, 1'b0);
        stepEdge(1'b0, 1'b1, 8'd255, 8'd255, 1'b0, 1'b0, 1'b0);
        period(1'b1, 1'b0, 1'b0);

        // Randomised edges with occasional resets and loads
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            stepEdge(r < 2, (r >= 2 && r < 7), 8'($urandom_range(0, 255)),
                     8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 20 && expQ.size() > 0; i++) @(posedge clk);
        if (expQ.size() > 0) begin
            testCnt++;
            failCnt++;
            $display("[TB] FAIL drain pending=%0d required=0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule

// File: doc/tank_plant_emulator.md
# tank_plant_emulator

Sequential emulator of the irrigation plant: the water reservoir and the soil bed. It is the far end of the irrigation controller's actuator/sensor interface. It consumes the valve commands (inlet Ve, sprinkler A, drip G) and produces the sensor signals the controller reads: tank level code Nv1/Nv0 and soil-dry flag Us. It runs on the board clock so the controller can be exercised on the FPGA without real hydraulics.

## Interface
Parameters:
- TICK_DIV, 50000000: clocks per simulation tick (≥2)
- VOL_MAX, 200: tank capacity, volume units (≤255)
- VOL_INIT, 100: volume after reset
- FILL_RATE, 8: units added per tick with Ve=1
- A_RATE, 6: units drawn per tick with A=1
- G_RATE, 2: units drawn per tick with G=1
- LVL1 / LVL2 / LVL3, 50 / 100 / 150: level-code thresholds, strictly increasing
- SOIL_MAX, 255: soil moisture ceiling
- SOIL_INIT, 40: soil moisture after reset
- A_GAIN / G_GAIN, 5 / 3: moisture gained per tick while the valve delivers
- DRY_RATE, 1: moisture lost per tick
- DRY_TH / WET_TH, 30 / 120: Us hysteresis thresholds, DRY_TH < WET_TH

Ports:
- Clk, in, 1: system clock
- Rst, in, 1: synchronous reset, active-high
- Ve, in, 1: inlet valve open
- A, in, 1: sprinkler valve open
- G, in, 1: drip valve open
- Ld, in, 1: test preload strobe
- LdVol, in, 8: preload volume
- LdSoil, in, 8: preload moisture
- Nv1, Nv0, out, 1 each: tank level code
- Us, out, 1: soil dry (1 = irrigation needed)
- Ovf, out, 1: one-cycle pulse, inlet open on a full tank
- DryRun, out, 1: one-cycle pulse, outlet open on an empty tank
- Vol, out, 8: current volume (debug)
- Soil, out, 8: current moisture (debug)

## Operation
- State: prescaler P (0..TICK_DIV-1), volume V (0..VOL_MAX), moisture M (0..SOIL_MAX), Us hysteresis register.
- Reset, Rst=1 at an edge:
  - P=0, V=VOL_INIT, M=SOIL_INIT.
  - Nv from VOL_INIT. Us = (SOIL_INIT ≤ DRY_TH).
  - Ovf=0, DryRun=0.
- Priority order: Rst > Ld > tick > idle.
- Ld=1 (Rst=0):
  - V = min(LdVol, VOL_MAX), M = min(LdSoil, SOIL_MAX), P=0.
  - No tick is processed that cycle. Nv and Us are recomputed from the loaded values, with hysteresis applied as on a tick.
- Tick: the cycle where P = TICK_DIV-1. P wraps to 0; otherwise P increments every cycle.
- On a tick, using pre-tick V:
  - Volume: V' = clamp(V + Ve·FILL_RATE − A·A_RATE − G·G_RATE, 0, VOL_MAX). Use a signed ≥10-bit intermediate; no wrap.
  - Moisture: M' = clamp(M + (V>0)·(A·A_GAIN + G·G_GAIN) − DRY_RATE, 0, SOIL_MAX). Valves on an empty tank deliver nothing.
  - Ovf = Ve & (V = VOL_MAX).
  - DryRun = (A|G) & (V = 0).
- Level code, from V: 00 if V<LVL1; 01 if V<LVL2; 10 if V<LVL3; 11 otherwise. Nv1 is the MSB.
- Us hysteresis, from M: set when M ≤ DRY_TH, clear when M ≥ WET_TH, hold otherwise.
- Ve, A and G may all be asserted together; the net is computed in one step.

## Timing
- All outputs are registered and change only at Clk rising edges.
- V, M, Nv, Us, Ovf and DryRun update on the tick edge itself. Nv and Us are derived from V'/M', so they are valid in the same cycle as the new Vol/Soil.
- Ovf and DryRun are high for exactly one cycle after the tick edge and 0 on all other cycles.
- Tick period is exactly TICK_DIV clocks. The first tick after reset or Ld is the TICK_DIV-th edge after it.
- Valve inputs are sampled only on the tick edge. Glitches between ticks have no effect.
- Rst asserted mid-period discards the partial period. Ld behaves the same way.

## Test plan
1. Rst with defaults → Vol=100, Soil=40, Nv=10, Us=0, Ovf=DryRun=0. With TICK_DIV=4, the first tick occurs on the 4th edge after Rst drops.
2. TICK_DIV=4, Ld V=195, Ve=1 for 2 ticks → Vol=200, then 200. Ovf pulses only on tick 2. Nv=11 throughout.
3. Ld V=7, Soil=100, A=1,G=1 → tick1: Vol=0, Soil=107. Tick2: Vol=0, Soil=106, DryRun=1 for one cycle. Nv=00.
4. Hysteresis: Ld Soil=31 (Us=0), all valves off → tick1: Soil=30, Us=1. Then Ld V=200, A=1, with Soil rising through 119 → Us stays 1. Us clears on the tick where Soil ≥ 120.
5. Ve=1, A=1, G=1 from V=100 → V=100 after each tick (8−6−2=0). Nv stays 10.
6. Rst asserted two cycles after Ld, and Ld asserted with LdVol=255 → Rst state wins. Ld alone yields Vol=200, P=0, and no tick that cycle.
